// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the PE row controller.
package pe_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    MODE_FP_S1 = 2'b00,
    MODE_FP_S2 = 2'b01,
    MODE_BP_S1 = 2'b10,
    MODE_BP_S2 = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Select word layout: {m0, m1, m2, m3, s0, s1}, indexed by mode_e.
  localparam logic [5:0] SEL_TBL [4] = '{6'b0000_10, 6'b1000_10, 6'b0011_01, 6'b1011_01};

  function automatic logic [5:0] sel_of(input mode_e m);
    return SEL_TBL[m];
  endfunction

endpackage

// File: rtl/pe_ctrl_vpipe.sv
// pe_ctrl_vpipe: LAT-deep valid/last delay line with synchronous flush.
module pe_ctrl_vpipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic v_in,
  input  logic last_in,
  output logic v_out,
  output logic last_out
);

  logic [LAT-1:0] v_r;
  logic [LAT-1:0] last_r;

  // Shift valid/last toward the output; flush drops every pending pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_r    <= {LAT{1'b0}};
      last_r <= {LAT{1'b0}};
    end else if (flush) begin
      v_r    <= {LAT{1'b0}};
      last_r <= {LAT{1'b0}};
    end else begin
      v_r[0]    <= v_in;
      last_r[0] <= last_in & v_in;
      for (int k = 1; k < LAT; k++) begin
        v_r[k]    <= v_r[k-1];
        last_r[k] <= last_r[k-1];
      end
    end
  end

  assign v_out    = v_r[LAT-1];
  assign last_out = last_r[LAT-1];

endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: row sequencer feeding a PE with three weights and sample pairs.
// Defining PE_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ROW_LEN = 16,
  parameter int PE_LAT  = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  output logic           busy,
  output logic           done,
  input  logic [N-1:0]   w_data,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [2*N-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   i0,
  output logic [N-1:0]   i1,
  output logic [N-1:0]   w0,
  output logic [N-1:0]   w1,
  output logic [N-1:0]   w2,
  output logic           select_m0,
  output logic           select_m1,
  output logic           select_m2,
  output logic           select_m3,
  output logic           select0,
  output logic           select1,
  output logic           pe_clr_n,
  output logic           psum_valid,
  output logic           psum_last
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_busy_cyc,
  output logic [31:0]    perf_stall_cyc
`endif
);

  localparam int BEATS = ROW_LEN / 2;
  localparam int BW    = $clog2(BEATS);
  localparam int DW    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);

  state_e        state_r, state_nxt_s;
  mode_e         mode_r;
  logic [1:0]    wcnt_r;
  logic [BW-1:0] bcnt_r;
  logic [DW-1:0] dcnt_r;
  logic [N-1:0]  w0_r, w1_r, w2_r, i0_r, i1_r;
  logic          busy_r, done_r, w_ready_r, in_ready_r, pe_clr_n_r;
  logic          ld_v_r, ld_last_r;
  logic          abort_s, accept_s, wbeat_s, beat_s;

  // Next-state decode; abort outranks every other transition.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    wbeat_s     = 1'b0;
    beat_s      = 1'b0;
    abort_s     = abort && (state_r != ST_IDLE);
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_LOAD_W;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD_W: begin
          if (w_valid && w_ready_r) begin
            wbeat_s     = 1'b1;
            state_nxt_s = (wcnt_r == 2'd2) ? ST_RUN : ST_LOAD_W;
          end else begin
            state_nxt_s = ST_LOAD_W;
          end
        end
        ST_RUN: begin
          if (in_valid && in_ready_r) begin
            beat_s      = 1'b1;
            state_nxt_s = (bcnt_r == LAST_BEAT) ? ST_DRAIN : ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (dcnt_r == DRAIN_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      w_ready_r  <= 1'b0;
      in_ready_r <= 1'b0;
      pe_clr_n_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_nxt_s == ST_DONE);
      w_ready_r  <= (state_nxt_s == ST_LOAD_W);
      in_ready_r <= (state_nxt_s == ST_RUN);
      pe_clr_n_r <= !((state_r == ST_LOAD_W) && (state_nxt_s == ST_RUN));
    end
  end

  // Mode latch and phase counters, all restarted by an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r <= MODE_FP_S1;
      wcnt_r <= 2'd0;
      bcnt_r <= BW'(0);
      dcnt_r <= DW'(0);
    end else if (accept_s) begin
      mode_r <= mode_e'(mode);
      wcnt_r <= 2'd0;
      bcnt_r <= BW'(0);
      dcnt_r <= DW'(0);
    end else begin
      if (wbeat_s) wcnt_r <= wcnt_r + 2'd1;
      if (beat_s) bcnt_r <= bcnt_r + BW'(1);
      if (state_r == ST_DRAIN) dcnt_r <= dcnt_r + DW'(1);
    end
  end

  // Operand registers; ld_v_r marks the cycle a fresh sample pair sits on i0/i1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w0_r      <= {N{1'b0}};
      w1_r      <= {N{1'b0}};
      w2_r      <= {N{1'b0}};
      i0_r      <= {N{1'b0}};
      i1_r      <= {N{1'b0}};
      ld_v_r    <= 1'b0;
      ld_last_r <= 1'b0;
    end else begin
      if (wbeat_s) begin
        case (wcnt_r)
          2'd0:    w0_r <= w_data;
          2'd1:    w1_r <= w_data;
          2'd2:    w2_r <= w_data;
          default: w2_r <= w2_r;
        endcase
      end
      if (beat_s) begin
        i0_r <= in_data[N-1:0];
        i1_r <= in_data[2*N-1:N];
      end
      ld_v_r    <= beat_s;
      ld_last_r <= beat_s && (bcnt_r == LAST_BEAT);
    end
  end

  pe_ctrl_vpipe #(
    .LAT (PE_LAT)
  ) u_vpipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (abort_s),
    .v_in     (ld_v_r),
    .last_in  (ld_last_r),
    .v_out    (psum_valid),
    .last_out (psum_last)
  );

`ifdef PE_CTRL_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  logic [31:0] perf_busy_r, perf_stall_r;

  // Saturating activity counters, zeroed by each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else if (accept_s) begin
      perf_busy_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if ((state_r != ST_IDLE) && (perf_busy_r != CNT_MAX)) perf_busy_r <= perf_busy_r + 32'd1;
      if ((state_r == ST_RUN) && !in_valid && (perf_stall_r != CNT_MAX))
        perf_stall_r <= perf_stall_r + 32'd1;
    end
  end

  assign perf_busy_cyc  = perf_busy_r;
  assign perf_stall_cyc = perf_stall_r;
`endif

  assign {select_m0, select_m1, select_m2, select_m3, select0, select1} = sel_of(mode_r);
  assign busy     = busy_r;
  assign done     = done_r;
  assign w_ready  = w_ready_r;
  assign in_ready = in_ready_r;
  assign pe_clr_n = pe_clr_n_r;
  assign i0       = i0_r;
  assign i1       = i1_r;
  assign w0       = w0_r;
  assign w1       = w1_r;
  assign w2       = w2_r;

endmodule
